// File: rtl/sparse_index_encoder.sv
// sparse_index_encoder: streams a layer's weights and packs one pruned/kept bit per
// group into an MSB-first sparsity bitmap for the lut_index tables.
module sparse_index_encoder #(
    parameter int IDX_W  = 648,
    parameter int ELEM_W = 8,
    parameter int GROUP  = 9,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        addr_in,
    input  logic [CNT_W-1:0]  num_groups,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ELEM_W-1:0] w_data,
    output logic [IDX_W-1:0]  sbyte,
    output logic [3:0]        addr_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  prune_cnt,
    output logic              err
);
    localparam int EW = $clog2(GROUP);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sbyte_q, sbyte_d;
    logic [3:0]         addr_q, addr_d;
    logic [CNT_W-1:0]   ngrp_q, ngrp_d;
    logic [CNT_W-1:0]   grp_q, grp_d;
    logic [CNT_W-1:0]   prune_q, prune_d;
    logic [EW-1:0]      elem_q, elem_d;
    logic               zacc_q, zacc_d;
    logic               err_q, err_d;
    logic               zbit;
    logic               start_ok;

    assign zbit     = zacc_q & (w_data == '0);
    assign start_ok = (num_groups != '0) && (num_groups <= CNT_W'(IDX_W));

    always_comb begin
        state_d = state_q;
        sbyte_d = sbyte_q;
        addr_d  = addr_q;
        ngrp_d  = ngrp_q;
        grp_d   = grp_q;
        prune_d = prune_q;
        elem_d  = elem_q;
        zacc_d  = zacc_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && start_ok) begin
                    addr_d  = addr_in;
                    ngrp_d  = num_groups;
                    sbyte_d = '0;
                    prune_d = '0;
                    grp_d   = '0;
                    elem_d  = '0;
                    zacc_d  = 1'b1;
                    state_d = COLLECT;
                end else begin
                    err_d = start;
                end
            end
            COLLECT: begin
                err_d = start;
                if (w_valid) begin
                    if (elem_q == EW'(GROUP - 1)) begin
                        // Group complete: its bit lands MSB-first at IDX_W-1-grp.
                        sbyte_d = sbyte_q | ({{(IDX_W-1){1'b0}}, zbit} << (IDX_W - 1 - int'(grp_q)));
                        prune_d = prune_q + CNT_W'(zbit);
                        grp_d   = grp_q + CNT_W'(1);
                        elem_d  = '0;
                        zacc_d  = 1'b1;
                        state_d = (grp_q + CNT_W'(1) == ngrp_q) ? DONE : COLLECT;
                    end else begin
                        elem_d = elem_q + EW'(1);
                        zacc_d = zbit;
                    end
                end
            end
            DONE: begin
                err_d   = start;
                state_d = out_ready ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sbyte_q <= '0;
            addr_q  <= '0;
            ngrp_q  <= '0;
            grp_q   <= '0;
            prune_q <= '0;
            elem_q  <= '0;
            zacc_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sbyte_q <= sbyte_d;
            addr_q  <= addr_d;
            ngrp_q  <= ngrp_d;
            grp_q   <= grp_d;
            prune_q <= prune_d;
            elem_q  <= elem_d;
            zacc_q  <= zacc_d;
            err_q   <= err_d;
        end
    end

    assign w_ready   = (state_q == COLLECT);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sbyte     = sbyte_q;
    assign addr_out  = addr_q;
    assign prune_cnt = prune_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sparse_index_encoder.sv
// tb_sparse_index_encoder: randomized layers checked by a scoreboard against a
// group-level reference model of the sparsity bitmap.
module tb_sparse_index_encoder;
    localparam int IDX_W = 27, ELEM_W = 8, GROUP = 9, CNT_W = 5;

    logic clk = 0, rst = 1, start = 0, w_valid = 0, out_ready = 0;
    logic [3:0] addr_in = 0;
    logic [CNT_W-1:0] num_groups = 0;
    logic [ELEM_W-1:0] w_data = 0;
    logic w_ready, out_valid, busy, err;
    logic [IDX_W-1:0] sbyte;
    logic [3:0] addr_out;
    logic [CNT_W-1:0] prune_cnt;

    typedef struct packed {
        logic [IDX_W-1:0] sb;
        logic [3:0]       a;
        logic [CNT_W-1:0] p;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit have = 0;
    int checks = 0, failures = 0, err_seen = 0;
    logic [ELEM_W-1:0] el[$];
    logic [IDX_W-1:0] last_sb = '0;

    sparse_index_encoder #(.IDX_W(IDX_W), .ELEM_W(ELEM_W), .GROUP(GROUP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .addr_in(addr_in), .num_groups(num_groups),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .sbyte(sbyte),
        .addr_out(addr_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .prune_cnt(prune_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: a group is pruned iff every one of its elements is zero.
    function automatic exp_t model(input logic [3:0] addr, input int ng);
        exp_t e;
        e.sb = '0;
        e.a  = addr;
        e.p  = '0;
        for (int k = 0; k < ng; k++) begin
            bit z = 1;
            for (int j = 0; j < GROUP; j++)
                if (el[k*GROUP + j] != 0) z = 0;
            if (z) begin
                e.sb[IDX_W-1-k] = 1'b1;
                e.p = e.p + 1'b1;
            end
        end
        return e;
    endfunction

    task automatic gen_layer(input int ng);
        el.delete();
        for (int k = 0; k < ng; k++) begin
            bit zero = 1'($urandom_range(0, 1));
            for (int j = 0; j < GROUP; j++)
                el.push_back(zero ? 8'd0 : ($urandom_range(0, 2) == 0 ? 8'd0 : 8'($urandom_range(1, 255))));
            if (!zero) el[k*GROUP + $urandom_range(0, GROUP-1)] = 8'($urandom_range(1, 255));
        end
    endtask

    // Monitor: pops one expectation per result and checks it on every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            have = 0;
        end else begin
            if (err) err_seen++;
            if (out_valid) begin
                if (!have) begin
                    if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
                    else begin
                        cur = q.pop_front();
                        have = 1;
                    end
                end
                if (have) begin
                    chk("sbyte", 64'(sbyte), 64'(cur.sb));
                    chk("addr_out", 64'(addr_out), 64'(cur.a));
                    chk("prune_cnt", 64'(prune_cnt), 64'(cur.p));
                    chk("done_w_ready", 64'(w_ready), 0);
                end
            end else begin
                have = 0;
            end
        end
    end

    task automatic run_layer(input logic [3:0] addr, input int ng, input bit gaps,
                             input int hold, input int pulse_at);
        exp_t e;
        int guard;
        e = model(addr, ng);
        @(negedge clk);
        start = 1; addr_in = addr; num_groups = CNT_W'(ng);
        q.push_back(e);
        @(negedge clk);
        start = 0;
        chk("busy_after_start", 64'(busy), 1);
        for (int i = 0; i < el.size(); i++) begin
            w_valid = 1; w_data = el[i];
            guard = 0;
            while (!w_ready && guard < 20) begin @(negedge clk); guard++; end
            if (guard == 20) chk("w_ready_timeout", 0, 1);
            @(negedge clk);
            if (i == el.size() - 1) begin
                w_valid = 0;
                chk("latency_out_valid", 64'(out_valid), 1);
                chk("w_ready_after_last", 64'(w_ready), 0);
            end else if (gaps) begin
                w_valid = 0; w_data = 8'($urandom_range(1, 255));
                @(negedge clk);
            end
        end
        for (int c = 0; c < hold; c++) begin
            start = (c == pulse_at);
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 1);
        end
        start = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("out_valid_cleared", 64'(out_valid), 0);
        chk("busy_cleared", 64'(busy), 0);
        last_sb = e.sb;
    endtask

    task automatic bad_start(input int ng);
        int e0;
        e0 = err_seen;
        @(negedge clk);
        start = 1; num_groups = CNT_W'(ng); addr_in = 4'hF;
        @(negedge clk);
        start = 0;
        repeat (3) begin
            chk("bad_start_busy", 64'(busy), 0);
            @(negedge clk);
        end
        chk("bad_start_err_pulses", 64'(err_seen - e0), 1);
        chk("bad_start_sbyte_kept", 64'(sbyte), 64'(last_sb));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        @(negedge clk);
        chk("reset_sbyte", 64'(sbyte), 0);
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_w_ready", 64'(w_ready), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_prune", 64'(prune_cnt), 0);
        chk("reset_err", 64'(err), 0);
        rst = 0;
        el.delete();
        for (int i = 0; i < 27; i++) el.push_back(8'd0);
        run_layer(4'b0001, 3, 0, 0, -1);
        el.delete();
        for (int i = 0; i < 27; i++) el.push_back(i == 17 ? 8'h05 : 8'h00);
        run_layer(4'h2, 3, 0, 0, -1);
        bad_start(0);
        bad_start(28);
        gen_layer(3);
        e0 = err_seen;
        run_layer(4'h7, 3, 0, 5, 2);
        chk("done_start_err_pulses", 64'(err_seen - e0), 1);
        gen_layer(2);
        run_layer(4'h5, 2, 1, 0, -1);
        run_layer(4'h5, 2, 0, 0, -1);
        gen_layer(3);
        @(negedge clk);
        start = 1; addr_in = 4'h9; num_groups = 3;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 13; i++) begin
            w_valid = 1; w_data = el[i];
            @(negedge clk);
        end
        w_valid = 0;
        rst = 1;
        #1;
        chk("abort_sbyte", 64'(sbyte), 0);
        chk("abort_addr", 64'(addr_out), 0);
        chk("abort_prune", 64'(prune_cnt), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_w_ready", 64'(w_ready), 0);
        chk("abort_out_valid", 64'(out_valid), 0);
        @(negedge clk);
        rst = 0;
        last_sb = '0;
        el.delete();
        for (int i = 0; i < GROUP; i++) el.push_back(8'($urandom_range(1, 255)));
        run_layer(4'h3, 1, 0, 0, -1);
        for (int t = 0; t < 20; t++) begin
            int ng = $urandom_range(1, IDX_W);
            gen_layer(ng);
            run_layer(4'($urandom_range(0, 15)), ng, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sparse_index_encoder.md
Name: sparse_index_encoder

Overview:
- Write-side counterpart of the per-layer sparsity index LUTs. It takes a layer's weights as a stream, one element per cycle, and builds the packed sparsity bitmap (sbyte) those LUTs store, with one bit per weight group.
- Sits between the offline or on-chip pruning path and index-table generation and capture.
- The emitted sbyte and 4-bit layer address use the same bit ordering and encoding the lut_index tables are read with.

Parameters:
- IDX_W, 648: bitmap width, the maximum number of groups per layer.
- ELEM_W, 8: weight element width.
- GROUP, 9: elements per group (one 3x3 kernel).
- CNT_W, 10: group counter width. Must satisfy 2^CNT_W > IDX_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a layer.
- addr_in  in  4  layer address, latched on an accepted start.
- num_groups  in  CNT_W  number of groups in this layer, latched on an accepted start.
- w_valid  in  1  weight element valid.
- w_ready  out  1  encoder can accept a weight element.
- w_data  in  ELEM_W  weight element.
- sbyte  out  IDX_W  packed sparsity bitmap.
- addr_out  out  4  latched layer address.
- out_valid  out  1  sbyte and addr_out are valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in COLLECT or DONE.
- prune_cnt  out  CNT_W  number of pruned groups in the current or last layer.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0: sbyte, addr_out, out_valid, w_ready, busy, prune_cnt, err. Internal counters 0, zero-accumulator 1.
- Encoding: bit=1 means the whole group is zero (pruned); bit=0 means kept. All-zero sbyte means a fully dense layer.
- Bit order: group k (0-based, in stream order) maps to sbyte[IDX_W-1-k], MSB first. Bits for k >= num_groups stay 0.
- Elements within a group arrive in order; elem_cnt counts 0..GROUP-1.
- State IDLE:
  - w_ready=0, out_valid=0, busy=0.
  - start with 1 <= num_groups <= IDX_W: latch addr_in and num_groups, clear sbyte/prune_cnt/counters, go to COLLECT next cycle.
  - start with num_groups=0 or num_groups>IDX_W: err=1 for exactly one cycle, remain IDLE, no registers change.
- State COLLECT:
  - w_ready=1, busy=1. An element transfers when w_valid & w_ready. Cycles with w_valid=0 change nothing.
  - On each transfer: zacc <= zacc & (w_data==0), elem_cnt increments.
  - On a transfer with elem_cnt==GROUP-1: sbyte[IDX_W-1-grp_cnt] <= zacc & (w_data==0), prune_cnt += that bit, grp_cnt increments, elem_cnt and zacc reset.
  - If that group was number num_groups-1, go to DONE. w_ready drops and out_valid rises on the following cycle, so latency from the final element handshake to out_valid is 1 cycle.
- State DONE:
  - out_valid=1, busy=1, w_ready=0. sbyte, addr_out and prune_cnt are held stable.
  - out_ready=1: go to IDLE; out_valid=0 next cycle.
  - sbyte/addr_out/prune_cnt keep their values in IDLE until the next accepted start.
- start while busy (COLLECT or DONE): ignored, err pulses for one cycle, no other effect.
- start in the same cycle as the DONE handshake: ignored with an err pulse, because state is still DONE in that cycle.
- rst asserted mid-COLLECT or in DONE: immediate return to the reset values. Any partial bitmap is discarded.
- Arithmetic: elem_cnt holds at most GROUP-1; grp_cnt and prune_cnt hold at most IDX_W. No wrap can occur with legal num_groups.

Test Plan (bench uses IDX_W=27, GROUP=9, ELEM_W=8, CNT_W=5):
1. start, addr_in=4'b0001, num_groups=3, then 27 zero elements on back-to-back cycles -> out_valid 1 cycle after the 27th handshake; sbyte=27'b111 followed by 24 zeros; addr_out=1; prune_cnt=3.
2. num_groups=3; group0 all zero, group1 has w_data=8'h05 at element 8 only, group2 all zero -> sbyte[26:24]=3'b101, other bits 0, prune_cnt=2.
3. start with num_groups=0, and separately with num_groups=28 -> err high exactly 1 cycle each time, busy stays 0, sbyte unchanged.
4. Complete a layer and hold out_ready=0 for 5 cycles, pulsing start in cycle 2 -> sbyte, addr_out and out_valid stay stable; err pulses once; then out_ready=1 -> IDLE and out_valid=0 next cycle.
5. w_valid toggled 1/0 each cycle over a 2-group layer -> same sbyte as the back-to-back run; only handshaked elements counted.
6. Assert rst after 13 elements of a 3-group layer -> all outputs 0 immediately; a fresh layer with num_groups=1 and nonzero data -> sbyte=0, prune_cnt=0, out_valid asserted.
